exc_request_ctrl: RTL and testbench

Source-side companion to the CP0 exception unit. It turns raw event lines and an internal periodic timer into per-source pending bits. It presents exactly one prioritised request at a time on the CP0 exception-source inputs and holds it until CP0 accepts. It then stays in service until the handler's ERET retires the request. This is the requester half of the CP0 exception-source interface. CP0 supplies the block mask, status block bit, accept and ERET back to this block.

---
 rtl/exc_request_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exc_request_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_request_ctrl.sv
// -----------------------------------------------------------------------------
// exc_request_ctrl
//
// Requester side of the CP0 exception-source interface. Raw event lines and
// an internal periodic timer become per-source pending bits. One request is
// presented at a time, with fixed priority (source 0 > 1 > 2). The request
// is held until CP0 accepts it. The block then stays in service until the
// handler's ERET retires the request.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   evt_in      raw level event lines; a rising edge is a new event
//   block_mask  per-source mask from CP0 (1 = masked)
//   exp_block   CP0 status[0]; while high no new request is launched
//   has_exp     CP0 accept of the current request
//   is_eret     ERET retiring this cycle
//   tmr_en      timer enable
//   tmr_period  timer period in cycles (0 = timer inert)
//   exp_src     one-hot request to CP0
//   pending     pending bits per source
//   busy        high while a request is outstanding or in service
//   svc_id      index of the source requested or in service
//   ovf_cnt     saturating count of events lost on already-pending sources
// -----------------------------------------------------------------------------
module exc_request_ctrl #(
   parameter int TIMER_W = 16,
   parameter int OVF_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         evt_in,
   input  logic [2:0]         block_mask,
   input  logic               exp_block,
   input  logic               has_exp,
   input  logic               is_eret,
   input  logic               tmr_en,
   input  logic [TIMER_W-1:0] tmr_period,
   output logic [2:0]         exp_src,
   output logic [2:0]         pending,
   output logic               busy,
   output logic [1:0]         svc_id,
   output logic [OVF_W-1:0]   ovf_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   // Index of the lowest set bit; source 0 has the highest priority.
   function automatic logic [1:0] lowest_idx(input logic [2:0] v);
      logic [1:0] idx;
      if (v[0])      idx = 2'd0;
      else if (v[1]) idx = 2'd1;
      else if (v[2]) idx = 2'd2;
      else           idx = 2'd0;
      return idx;
   endfunction

   // One-hot decode of a source index.
   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   state_e             state_q, state_d;
   logic [2:0]         evt_q;
   logic [2:0]         pending_q, pending_d;
   logic [TIMER_W-1:0] tmr_cnt_q, tmr_cnt_d;
   logic [1:0]         svc_id_q, svc_id_d;
   logic [OVF_W-1:0]   ovf_cnt_q, ovf_cnt_d;

   logic               tmr_active_s;
   logic               tmr_hit_s;
   logic [2:0]         new_s;
   logic [2:0]         clr_s;
   logic [2:0]         lost_s;
   logic [1:0]         lost_cnt_s;
   logic [OVF_W:0]     ovf_sum_s;
   logic [2:0]         eligible_s;

   // Timer, event capture, pending bookkeeping and lost-event counting.
   always_comb begin
      tmr_active_s = tmr_en && (tmr_period != {TIMER_W{1'b0}});
      tmr_hit_s    = tmr_active_s && (tmr_cnt_q == (tmr_period - TIMER_W'(1)));
      if (!tmr_active_s) begin
         tmr_cnt_d = {TIMER_W{1'b0}};
      end else if (tmr_hit_s) begin
         tmr_cnt_d = {TIMER_W{1'b0}};
      end else begin
         tmr_cnt_d = tmr_cnt_q + TIMER_W'(1);
      end

      new_s = (evt_in & ~evt_q) | {tmr_hit_s, 2'b00};

      // ERET clears the serviced source, but a new event on it the same cycle wins.
      if ((state_q == ST_SERVICE) && is_eret) begin
         clr_s = onehot3(svc_id_q);
      end else begin
         clr_s = 3'b000;
      end

      lost_s     = new_s & pending_q & ~clr_s;
      lost_cnt_s = {1'b0, lost_s[0]} + {1'b0, lost_s[1]} + {1'b0, lost_s[2]};
      ovf_sum_s  = {1'b0, ovf_cnt_q} + (OVF_W + 1)'(lost_cnt_s);
      if (ovf_sum_s[OVF_W]) begin
         ovf_cnt_d = {OVF_W{1'b1}};
      end else begin
         ovf_cnt_d = ovf_sum_s[OVF_W-1:0];
      end

      pending_d  = (pending_q & ~clr_s) | new_s;
      eligible_s = pending_q & ~block_mask;
   end

   // Request FSM next-state logic.
   always_comb begin
      state_d  = state_q;
      svc_id_d = svc_id_q;
      case (state_q)
         ST_IDLE: begin
            if ((eligible_s != 3'b000) && !exp_block) begin
               state_d  = ST_REQ;
               svc_id_d = lowest_idx(eligible_s);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            // Accept beats withdrawal when both happen in one cycle.
            if (has_exp) begin
               state_d = ST_SERVICE;
            end else if (((block_mask & onehot3(svc_id_q)) != 3'b000) || exp_block) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (is_eret) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_SERVICE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         evt_q     <= 3'b000;
         pending_q <= 3'b000;
         tmr_cnt_q <= {TIMER_W{1'b0}};
         svc_id_q  <= 2'd0;
         ovf_cnt_q <= {OVF_W{1'b0}};
      end else begin
         state_q   <= state_d;
         evt_q     <= evt_in;
         pending_q <= pending_d;
         tmr_cnt_q <= tmr_cnt_d;
         svc_id_q  <= svc_id_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   // Request is decoded from registered state only, so it cannot glitch.
   assign exp_src = (state_q == ST_REQ) ? onehot3(svc_id_q) : 3'b000;
   assign busy    = (state_q != ST_IDLE);
   assign pending = pending_q;
   assign svc_id  = svc_id_q;
   assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_request_ctrl
//
// Directed bench for exc_request_ctrl. Inputs change and outputs are sampled
// on the falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_exc_request_ctrl;

   logic        clk;
   logic        rst;
   logic [2:0]  evt_in;
   logic [2:0]  block_mask;
   logic        exp_block;
   logic        has_exp;
   logic        is_eret;
   logic        tmr_en;
   logic [15:0] tmr_period;
   logic [2:0]  exp_src;
   logic [2:0]  pending;
   logic        busy;
   logic [1:0]  svc_id;
   logic [7:0]  ovf_cnt;

   int checks;
   int errors;

   exc_request_ctrl #(.TIMER_W(16), .OVF_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .evt_in     (evt_in),
      .block_mask (block_mask),
      .exp_block  (exp_block),
      .has_exp    (has_exp),
      .is_eret    (is_eret),
      .tmr_en     (tmr_en),
      .tmr_period (tmr_period),
      .exp_src    (exp_src),
      .pending    (pending),
      .busy       (busy),
      .svc_id     (svc_id),
      .ovf_cnt    (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      evt_in = 3'b000; block_mask = 3'b000; exp_block = 1'b0; has_exp = 1'b0;
      is_eret = 1'b0; tmr_en = 1'b0; tmr_period = 16'd0;
      do_reset();
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL rst_exp_src got %b want %b", exp_src, 3'b000); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want %b", busy, 1'b0); end
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rst_pending got %b want %b", pending, 3'b000); end
      checks++; if (svc_id !== 2'd0) begin errors++; $display("FAIL rst_svc_id got %0d want %0d", svc_id, 0); end
      checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL rst_ovf got %0d want %0d", ovf_cnt, 0); end
   endtask

   task automatic test_single();
      evt_in = 3'b010;
      tick(1);
      checks++; if (pending !== 3'b010) begin errors++; $display("FAIL single_pend got %b want %b", pending, 3'b010); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got %b want %b", busy, 1'b0); end
      evt_in = 3'b000;
      tick(1);
      checks++; if (exp_src !== 3'b010) begin errors++; $display("FAIL single_req got %b want %b", exp_src, 3'b010); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want %b", busy, 1'b1); end
      checks++; if (svc_id !== 2'd1) begin errors++; $display("FAIL single_id got %0d want %0d", svc_id, 1); end
      has_exp = 1'b1;
      tick(1);
      has_exp = 1'b0;
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL single_acc got %b want %b", exp_src, 3'b000); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_svc_busy got %b want %b", busy, 1'b1); end
      is_eret = 1'b1;
      tick(1);
      is_eret = 1'b0;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_eret_pend got %b want %b", pending, 3'b000); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_eret_busy got %b want %b", busy, 1'b0); end
   endtask

   task automatic test_priority();
      evt_in = 3'b101;
      tick(1);
      evt_in = 3'b000;
      checks++; if (pending !== 3'b101) begin errors++; $display("FAIL prio_pend got %b want %b", pending, 3'b101); end
      tick(1);
      checks++; if (exp_src !== 3'b001) begin errors++; $display("FAIL prio_first got %b want %b", exp_src, 3'b001); end
      checks++; if (svc_id !== 2'd0) begin errors++; $display("FAIL prio_id got %0d want %0d", svc_id, 0); end
      has_exp = 1'b1; tick(1); has_exp = 1'b0;
      is_eret = 1'b1; tick(1); is_eret = 1'b0;
      checks++; if (pending !== 3'b100) begin errors++; $display("FAIL prio_after_eret got %b want %b", pending, 3'b100); end
      tick(1);
      checks++; if (exp_src !== 3'b100) begin errors++; $display("FAIL prio_second got %b want %b", exp_src, 3'b100); end
      has_exp = 1'b1; tick(1); has_exp = 1'b0;
      is_eret = 1'b1; tick(1); is_eret = 1'b0;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL prio_clean got %b want %b", pending, 3'b000); end
   endtask

   task automatic test_withdraw();
      evt_in = 3'b001; tick(1); evt_in = 3'b000;
      tick(1);
      checks++; if (exp_src !== 3'b001) begin errors++; $display("FAIL wd_req got %b want %b", exp_src, 3'b001); end
      block_mask = 3'b001;
      tick(1);
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL wd_drop got %b want %b", exp_src, 3'b000); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy got %b want %b", busy, 1'b0); end
      checks++; if (pending !== 3'b001) begin errors++; $display("FAIL wd_pend got %b want %b", pending, 3'b001); end
      tick(1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_masked_idle got %b want %b", busy, 1'b0); end
      block_mask = 3'b000;
      tick(1);
      checks++; if (exp_src !== 3'b001) begin errors++; $display("FAIL wd_reissue got %b want %b", exp_src, 3'b001); end
      // accept and mask in the same cycle: accept wins
      block_mask = 3'b001; has_exp = 1'b1;
      tick(1);
      block_mask = 3'b000; has_exp = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wd_acc_wins_busy got %b want %b", busy, 1'b1); end
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL wd_acc_wins_src got %b want %b", exp_src, 3'b000); end
      is_eret = 1'b1; tick(1); is_eret = 1'b0;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL wd_clean got %b want %b", pending, 3'b000); end
   endtask

   task automatic test_timer();
      tmr_en = 1'b1; tmr_period = 16'd5;
      tick(4);
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL tmr_early got %b want %b", pending, 3'b000); end
      tick(1);
      checks++; if (pending !== 3'b100) begin errors++; $display("FAIL tmr_hit got %b want %b", pending, 3'b100); end
      checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL tmr_ovf0 got %0d want %0d", ovf_cnt, 0); end
      tick(4);
      checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL tmr_ovf0b got %0d want %0d", ovf_cnt, 0); end
      tick(1);
      checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL tmr_ovf1 got %0d want %0d", ovf_cnt, 1); end
      checks++; if (exp_src !== 3'b100) begin errors++; $display("FAIL tmr_req got %b want %b", exp_src, 3'b100); end
      tick(5);
      checks++; if (ovf_cnt !== 8'd2) begin errors++; $display("FAIL tmr_ovf2 got %0d want %0d", ovf_cnt, 2); end
      tmr_period = 16'd1;
      tick(252);
      checks++; if (ovf_cnt !== 8'd254) begin errors++; $display("FAIL tmr_ovf254 got %0d want %0d", ovf_cnt, 254); end
      tick(1);
      checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL tmr_ovf255 got %0d want %0d", ovf_cnt, 255); end
      tick(5);
      checks++; if (ovf_cnt !== 8'd255) begin errors++; $display("FAIL tmr_sat got %0d want %0d", ovf_cnt, 255); end
      tmr_en = 1'b0; tmr_period = 16'd0;
      do_reset();
      checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL tmr_rst_ovf got %0d want %0d", ovf_cnt, 0); end
   endtask

   task automatic test_eret_collide();
      evt_in = 3'b010; tick(1); evt_in = 3'b000;
      tick(1);
      has_exp = 1'b1; tick(1); has_exp = 1'b0;
      is_eret = 1'b1; evt_in = 3'b010;
      tick(1);
      is_eret = 1'b0;
      checks++; if (pending !== 3'b010) begin errors++; $display("FAIL col_pend got %b want %b", pending, 3'b010); end
      checks++; if (ovf_cnt !== 8'd0) begin errors++; $display("FAIL col_ovf got %0d want %0d", ovf_cnt, 0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL col_busy got %b want %b", busy, 1'b0); end
      tick(1);
      evt_in = 3'b000;
      checks++; if (exp_src !== 3'b010) begin errors++; $display("FAIL col_rereq got %b want %b", exp_src, 3'b010); end
      has_exp = 1'b1; tick(1); has_exp = 1'b0;
      is_eret = 1'b1; tick(1); is_eret = 1'b0;
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL col_clean got %b want %b", pending, 3'b000); end
   endtask

   task automatic test_block_and_reset();
      exp_block = 1'b1;
      evt_in = 3'b111; tick(1); evt_in = 3'b000;
      checks++; if (pending !== 3'b111) begin errors++; $display("FAIL blk_pend got %b want %b", pending, 3'b111); end
      tick(2);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL blk_busy got %b want %b", busy, 1'b0); end
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL blk_src got %b want %b", exp_src, 3'b000); end
      exp_block = 1'b0;
      tick(1);
      checks++; if (exp_src !== 3'b001) begin errors++; $display("FAIL blk_release got %b want %b", exp_src, 3'b001); end
      has_exp = 1'b1; tick(1); has_exp = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL blk_svc got %b want %b", busy, 1'b1); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstsvc_busy got %b want %b", busy, 1'b0); end
      checks++; if (exp_src !== 3'b000) begin errors++; $display("FAIL rstsvc_src got %b want %b", exp_src, 3'b000); end
      checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rstsvc_pend got %b want %b", pending, 3'b000); end
      checks++; if (svc_id !== 2'd0) begin errors++; $display("FAIL rstsvc_id got %0d want %0d", svc_id, 0); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      test_reset();
      test_single();
      test_priority();
      test_withdraw();
      test_timer();
      test_eret_collide();
      test_block_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
